// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_tx
// Brief    : I2S DAC transmitter with codec warm-up, sample latch and
//            per-frame data_over next-sample handshake (mono on both slots).
//            Optional volume attenuation enabled by macro AUDIO_TX_VOL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module audio_i2s_tx #(
  parameter int BCLK_DIV   = 25,
  parameter int SAMPLE_W   = 16,
  parameter int WARMUP_CYC = 1000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                INIT,
  input  logic [16:0]         Add,
  input  logic [SAMPLE_W-1:0] sample_data,
`ifdef AUDIO_TX_VOL_EN
  input  logic [2:0]          vol,
`endif
  output logic                INIT_FINISH,
  output logic                data_over,
  output logic                AUD_BCLK,
  output logic                AUD_DACLRCK,
  output logic                AUD_DACDAT
);

  localparam int DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W  = $clog2(2 * SAMPLE_W);
  localparam int WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WARM_W-1:0]   warm_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [BIT_W-1:0]    bit_next;
  logic [SAMPLE_W-1:0] hold;
  logic [SAMPLE_W-1:0] shreg;
  logic [SAMPLE_W-1:0] load_word;
  logic [16:0]         add_ref;
  logic                running;
  logic                div_tc;
  logic                fall;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (INIT) begin
          state_next = (WARMUP_CYC <= 1) ? RUN : WARM;
        end
      end
      WARM: begin
        if (!INIT) begin
          state_next = IDLE;
        end else if (warm_cnt == WARM_W'(WARMUP_CYC - 1)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!INIT) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The IDLE->WARM edge is the first warm-up cycle, so counting starts at 1.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      warm_cnt <= '0;
    end else if (state_next == WARM) begin
      warm_cnt <= (state == WARM) ? warm_cnt + 1'b1 : WARM_W'(1);
    end else begin
      warm_cnt <= '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      INIT_FINISH <= 1'b0;
    end else begin
      INIT_FINISH <= (state_next == RUN);
    end
  end

  // The RUN-entry edge also clears, so the first BCLK toggle is a full BCLK_DIV later.
  assign running  = (state == RUN) && (state_next == RUN);
  assign div_tc   = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign fall     = running && div_tc && AUD_BCLK;
  assign bit_next = (bit_cnt == BIT_W'(2 * SAMPLE_W - 1)) ? '0 : bit_cnt + 1'b1;

`ifdef AUDIO_TX_VOL_EN
  assign load_word = $signed(hold) >>> vol;
`else
  assign load_word = hold;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      hold        <= '0;
      shreg       <= '0;
      add_ref     <= '0;
      data_over   <= 1'b0;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
    end else if (!running) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      hold        <= '0;
      shreg       <= '0;
      add_ref     <= '0;
      data_over   <= 1'b0;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
    end else begin
      if (div_tc) begin
        div_cnt  <= '0;
        AUD_BCLK <= ~AUD_BCLK;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (fall) begin
        bit_cnt     <= bit_next;
        AUD_DACLRCK <= (bit_next >= BIT_W'(SAMPLE_W));
        // Slots load one bit after the LRCK change; the slot's first bit carries the previous LSB.
        if ((bit_next == BIT_W'(1)) || (bit_next == BIT_W'(SAMPLE_W + 1))) begin
          shreg      <= load_word;
          AUD_DACDAT <= load_word[SAMPLE_W-1];
        end else begin
          shreg      <= shreg << 1;
          AUD_DACDAT <= shreg[SAMPLE_W-2];
        end
      end

      if (fall && (bit_next == '0)) begin
        hold      <= sample_data;
        add_ref   <= Add;
        data_over <= 1'b1;
      end else if (data_over && (Add != add_ref)) begin
        data_over <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// Bench for audio_i2s_tx: table-driven frames checked by a word-level scoreboard,
// plus warm-up timing, INIT drop and asynchronous mid-frame reset sequences.
module tb_audio_i2s_tx;

  localparam int BCLK_DIV   = 25;
  localparam int SAMPLE_W   = 16;
  localparam int WARMUP_CYC = 1000;
  localparam int FRAME_CYC  = 64 * BCLK_DIV;
  localparam int NV         = 7;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        INIT = 1'b0;
  logic [16:0] Add = '0;
  logic [15:0] sample_data = '0;
`ifdef AUDIO_TX_VOL_EN
  logic [2:0]  vol = '0;
`endif
  logic        INIT_FINISH;
  logic        data_over;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_DACDAT;

  audio_i2s_tx #(
    .BCLK_DIV   (BCLK_DIV),
    .SAMPLE_W   (SAMPLE_W),
    .WARMUP_CYC (WARMUP_CYC)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .INIT        (INIT),
    .Add         (Add),
    .sample_data (sample_data),
`ifdef AUDIO_TX_VOL_EN
    .vol         (vol),
`endif
    .INIT_FINISH (INIT_FINISH),
    .data_over   (data_over),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct {
    logic [16:0] add;
    logic [15:0] sample;
    logic [2:0]  v;
    logic [15:0] exp_plain;
    logic [15:0] exp_vol;
    bit          hold_add;
  } vec_t;

  vec_t        vecs[NV];
  logic [15:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_init_finish"}, 32'(INIT_FINISH), 0);
    check({name, "_data_over"},   32'(data_over),   0);
    check({name, "_bclk"},        32'(AUD_BCLK),    0);
    check({name, "_lrck"},        32'(AUD_DACLRCK), 0);
    check({name, "_dat"},         32'(AUD_DACDAT),  0);
  endtask

  function automatic logic [15:0] exp_word(input vec_t t);
`ifdef AUDIO_TX_VOL_EN
    return t.exp_vol;
`else
    return t.exp_plain;
`endif
  endfunction

  task automatic wait_lrck_fall(output bit ok);
    logic prev;
    int   n;
    prev = AUD_DACLRCK;
    ok   = 1'b0;
    n    = 0;
    while (!ok && n < 2 * FRAME_CYC) begin
      @(posedge Clk);
      #1;
      n++;
      if (prev && !AUD_DACLRCK) ok = 1'b1;
      prev = AUD_DACLRCK;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL lrck_fall_timeout: got none expected fall within %0d cycles", 2 * FRAME_CYC);
    end
  endtask

  // Word monitor: each LRCK change seen on a BCLK rise completes the previous slot's word.
  bit          mon_en = 1'b0;
  bit          started = 1'b0;
  logic        prev_lrck = 1'b0;
  logic        prev_bclk = 1'b0;
  logic [15:0] word = '0;
  logic [15:0] exp_w;

  always @(posedge Clk) begin
    #1;
    if (!mon_en) begin
      started   = 1'b0;
      prev_bclk = 1'b0;
    end else begin
      if (AUD_BCLK && !prev_bclk) begin
        word = {word[14:0], AUD_DACDAT};
        if (!started) begin
          started   = 1'b1;
          prev_lrck = AUD_DACLRCK;
        end else if (AUD_DACLRCK != prev_lrck) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_empty: got word %h expected no word", word);
          end else begin
            exp_w = sb.pop_front();
            check(prev_lrck ? "right_word" : "left_word", 32'(word), 32'(exp_w));
          end
          prev_lrck = AUD_DACLRCK;
        end
      end
      prev_bclk = AUD_BCLK;
    end
  end

  initial begin
    repeat (100000) @(posedge Clk);
    fails++;
    $display("FAIL watchdog: got no finish expected finish within 100000 cycles");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : main
    int n;
    int cnt;
    int last_fall;
    bit ok;
    logic prevb;

    vecs[0] = '{17'd5,     16'hA5C3, 3'd0, 16'hA5C3, 16'hA5C3, 1'b0};
    vecs[1] = '{17'd6,     16'h0000, 3'd4, 16'h0000, 16'h0000, 1'b0};
    vecs[2] = '{17'd7,     16'hFFFF, 3'd1, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[3] = '{17'd43113, 16'h8000, 3'd2, 16'h8000, 16'hE000, 1'b0};
    vecs[4] = '{17'd0,     16'h7FFF, 3'd0, 16'h7FFF, 16'h7FFF, 1'b0};
    vecs[5] = '{17'd0,     16'h7FFF, 3'd0, 16'h7FFF, 16'h7FFF, 1'b1};
    vecs[6] = '{17'd1,     16'h1234, 3'd3, 16'h1234, 16'h0246, 1'b0};

    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check_zero("reset");
    Reset = 1'b0;

    Add = vecs[0].add;
    sample_data = vecs[0].sample;
`ifdef AUDIO_TX_VOL_EN
    vol = vecs[0].v;
`endif
    sb.push_back(16'h0000);
    sb.push_back(16'h0000);
    sb.push_back(exp_word(vecs[0]));
    sb.push_back(exp_word(vecs[0]));
    mon_en = 1'b1;

    @(posedge Clk);
    #1;
    check_zero("idle");
    INIT = 1'b1;
    n = 0;
    do begin @(posedge Clk); #1; n++; end while (!INIT_FINISH && n < WARMUP_CYC + 20);
    check("init_finish_delay", 32'(n), 32'(WARMUP_CYC));
    n = 0;
    do begin @(posedge Clk); #1; n++; end while (!AUD_BCLK && n < BCLK_DIV + 20);
    check("first_bclk_rise", 32'(n), 32'(BCLK_DIV));
    check("data_over_frame0", 32'(data_over), 0);
    check("lrck_frame0", 32'(AUD_DACLRCK), 0);

    last_fall = -1;
    for (int i = 1; i < NV; i++) begin
      wait_lrck_fall(ok);
      if (!ok) break;
      if (last_fall >= 0) check("lrck_period", 32'(cyc - last_fall), 32'(FRAME_CYC));
      last_fall = cyc;
      check("data_over_set", 32'(data_over), 1);
      @(posedge Clk); #1;
      @(posedge Clk); #1;
`ifdef AUDIO_TX_VOL_EN
      vol = vecs[i-1].v;
`endif
      if (!vecs[i].hold_add) Add = vecs[i].add;
      sample_data = vecs[i].sample;
      sb.push_back(exp_word(vecs[i]));
      sb.push_back(exp_word(vecs[i]));
      check("data_over_hold", 32'(data_over), 1);
      @(posedge Clk); #1;
      check("data_over_clear", 32'(data_over), vecs[i].hold_add ? 32'd1 : 32'd0);
    end

    wait_lrck_fall(ok);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
`ifdef AUDIO_TX_VOL_EN
    vol = vecs[NV-1].v;
`endif
    wait_lrck_fall(ok);
    repeat (3 * BCLK_DIV) @(posedge Clk);
    #1;
    mon_en = 1'b0;
    check("sb_drained", 32'(sb.size()), 0);

    n = 0;
    while (!AUD_BCLK && n < 4 * BCLK_DIV) begin @(posedge Clk); #1; n++; end
    check("bclk_high_before_drop", 32'(AUD_BCLK), 1);
    INIT = 1'b0;
    @(posedge Clk); #1;
    check_zero("init_drop");

    INIT = 1'b1;
    n = 0;
    do begin @(posedge Clk); #1; n++; end while (!INIT_FINISH && n < WARMUP_CYC + 20);
    check("init_finish_restart", 32'(INIT_FINISH), 1);
    n = 0;
    cnt = 0;
    prevb = AUD_BCLK;
    while (cnt < 7 && n < 20 * BCLK_DIV) begin
      @(posedge Clk); #1;
      n++;
      if (prevb && !AUD_BCLK) cnt++;
      prevb = AUD_BCLK;
    end
    check("bitcnt7_reached", 32'(cnt), 7);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_zero("async_reset");

    sb.delete();
    Add = 17'd200;
    sample_data = 16'h3C5A;
`ifdef AUDIO_TX_VOL_EN
    vol = 3'd0;
`endif
    sb.push_back(16'h0000);
    sb.push_back(16'h0000);
    sb.push_back(16'h3C5A);
    sb.push_back(16'h3C5A);
    @(negedge Clk);
    Reset = 1'b0;
    mon_en = 1'b1;
    n = 0;
    do begin @(posedge Clk); #1; n++; end while (!INIT_FINISH && n < WARMUP_CYC + 20);
    check("init_finish_after_reset", 32'(n), 32'(WARMUP_CYC));
    wait_lrck_fall(ok);
    check("data_over_set_restart", 32'(data_over), 1);
    wait_lrck_fall(ok);
    repeat (3 * BCLK_DIV) @(posedge Clk);
    #1;
    mon_en = 1'b0;
    check("sb_drained_restart", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
